// File: rtl/tnn_pkg.sv
// Shared widths, types and default thresholds for the TNN feature loader.
// Also holds the quantizer sub-module and the loader top.
package tnn_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned FEAT_W  = 3;
  localparam int unsigned NFEAT   = 6;
  localparam int unsigned NTHRESH = (1 << FEAT_W) - 1;

  typedef logic [FEAT_W-1:0]         feat_t;
  typedef logic [2:0]                idx_t;
  typedef logic [NTHRESH*DATA_W-1:0] thresh_t;

  // Entry k sits at bits [k*DATA_W +: DATA_W]; entries must be strictly increasing.
  localparam thresh_t THRESH_DEFAULT = {8'd224, 8'd192, 8'd160, 8'd128, 8'd96, 8'd64, 8'd32};

  typedef enum logic {StFill, StHold} state_e;

endpackage

// File: rtl/tnn_thermo_quant.sv
// Thermometer quantizer: the output is the number of thresholds that the raw value reaches.
module tnn_thermo_quant
  import tnn_pkg::*;
#(
  parameter thresh_t THRESH = THRESH_DEFAULT
) (
  input  logic [DATA_W-1:0] i_data,
  output feat_t             o_q
);

  always_comb begin
    o_q = '0;
    for (int k = 0; k < NTHRESH; k++) begin
      if (i_data >= THRESH[k*DATA_W +: DATA_W]) o_q = o_q + feat_t'(1);
    end
  end

endmodule

// File: rtl/tnn_feature_loader.sv
// Collects six quantized feature beats into one sample for the classifier core.
// The assembly and output registers form a double buffer, so input keeps flowing while the output drains.
module tnn_feature_loader
  import tnn_pkg::*;
#(
  parameter thresh_t     THRESH = THRESH_DEFAULT,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output feat_t             out_a,
  output feat_t             out_b,
  output feat_t             out_c,
  output feat_t             out_d,
  output feat_t             out_e,
  output feat_t             out_f,
  output logic              m_short,
  output logic [CNT_W-1:0]  sample_cnt
);

  state_e           r_state;
  logic             r_s_ready;
  logic             r_m_valid;
  logic             r_m_short;
  logic             r_asm_short;
  idx_t             r_idx;
  feat_t            r_asm [NFEAT];
  feat_t            r_out [NFEAT];
  logic [CNT_W-1:0] r_cnt;

  feat_t w_q;
  feat_t w_merged [NFEAT];
  logic  w_accept;
  logic  w_last_slot;
  logic  w_complete;
  logic  w_short;
  logic  w_free;

  tnn_thermo_quant #(
    .THRESH (THRESH)
  ) u_quant (
    .i_data (s_data),
    .o_q    (w_q)
  );

  assign w_accept    = s_valid && r_s_ready;
  assign w_last_slot = (r_idx == idx_t'(NFEAT - 1));
  assign w_complete  = w_accept && (w_last_slot || s_last);
  assign w_short     = s_last && !w_last_slot;
  assign w_free      = !r_m_valid || m_ready;

  // Slots above the current index are zeroed, which handles the zero fill of a short sample.
  always_comb begin
    for (int i = 0; i < NFEAT; i++) begin
      if (idx_t'(i) < r_idx) begin
        w_merged[i] = r_asm[i];
      end else if (idx_t'(i) == r_idx) begin
        w_merged[i] = w_q;
      end else begin
        w_merged[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StFill;
      r_s_ready   <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_short   <= 1'b0;
      r_asm_short <= 1'b0;
      r_idx       <= '0;
      r_cnt       <= '0;
      for (int i = 0; i < NFEAT; i++) begin
        r_asm[i] <= '0;
        r_out[i] <= '0;
      end
    end else begin
      if (r_m_valid && m_ready) begin
        r_m_valid <= 1'b0;
        r_cnt     <= r_cnt + CNT_W'(1);
      end
      if (w_accept) begin
        for (int i = 0; i < NFEAT; i++) r_asm[i] <= w_merged[i];
        r_idx <= w_complete ? '0 : r_idx + idx_t'(1);
        if (w_complete) r_asm_short <= w_short;
      end
      unique case (r_state)
        StFill: begin
          r_s_ready <= 1'b1;
          if (w_complete) begin
            if (w_free) begin
              for (int i = 0; i < NFEAT; i++) r_out[i] <= w_merged[i];
              r_m_short <= w_short;
              r_m_valid <= 1'b1;
            end else begin
              r_state   <= StHold;
              r_s_ready <= 1'b0;
            end
          end
        end
        StHold: begin
          if (w_free) begin
            for (int i = 0; i < NFEAT; i++) r_out[i] <= r_asm[i];
            r_m_short <= r_asm_short;
            r_m_valid <= 1'b1;
            r_state   <= StFill;
            r_s_ready <= 1'b1;
          end
        end
        default: r_state <= StFill;
      endcase
    end
  end

  assign s_ready    = r_s_ready;
  assign m_valid    = r_m_valid;
  assign m_short    = r_m_short;
  assign sample_cnt = r_cnt;
  assign out_a      = r_out[0];
  assign out_b      = r_out[1];
  assign out_c      = r_out[2];
  assign out_d      = r_out[3];
  assign out_e      = r_out[4];
  assign out_f      = r_out[5];

endmodule

// File: tb/tb_tnn_feature_loader.sv
// Randomized bench for tnn_feature_loader.
// A queue-based sample model predicts every delivered sample and the delivery count.
module tb_tnn_feature_loader;
  import tnn_pkg::*;

  localparam int unsigned CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_last = 1'b0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  feat_t             out_a, out_b, out_c, out_d, out_e, out_f;
  logic              m_short;
  logic [CNT_W-1:0]  sample_cnt;

  tnn_feature_loader #(
    .THRESH (THRESH_DEFAULT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_c      (out_c),
    .out_d      (out_d),
    .out_e      (out_e),
    .out_f      (out_f),
    .m_short    (m_short),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int model_cnt = 0;
  int ready_drops = 0;
  bit track_ready = 0;
  int cur[$];
  logic [18:0] exp_q[$];  // {short, a, b, c, d, e, f}

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Default thresholds are the multiples of 32, so each level is one 32-wide bin.
  function automatic int ref_q(input int d);
    return d / 32;
  endfunction

  function automatic logic [17:0] outs();
    return {out_a, out_b, out_c, out_d, out_e, out_f};
  endfunction

  task automatic model_accept(input int d, input bit l);
    logic [18:0] s;
    cur.push_back(ref_q(d));
    if (cur.size() == 6 || l) begin
      s = '0;
      s[18] = (cur.size() < 6);
      for (int i = 0; i < cur.size(); i++) s[17-3*i -: 3] = 3'(cur[i]);
      exp_q.push_back(s);
      cur.delete();
    end
  endtask

  // Sample just after the falling edge; the handshake seen here happens at the next rising edge.
  always @(negedge clk) begin
    #1;
    if (track_ready && !s_ready) ready_drops++;
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_sample", 32'(m_valid), 32'd0);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        check_eq("sample_feats", 32'(outs()), 32'(e[17:0]));
        check_eq("sample_short", 32'(m_short), 32'(e[18]));
      end
      model_cnt++;
    end
  end

  // Called at a falling edge; returns at the falling edge after the beat is taken.
  task automatic send_beat(input int d, input bit l);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = 8'(d);
    s_last  = l;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("beat_accept", 32'(s_ready), 32'd1);
    if (s_ready) model_accept(d, l);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic send_rand_sample(input int n, input bit with_last);
    for (int i = 0; i < n; i++) send_beat(int'($urandom_range(0, 255)), with_last && (i == n - 1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_s_ready", 32'(s_ready), 32'd0);
    check_eq("rst_outs", 32'({outs(), m_short}), 32'd0);
    check_eq("rst_cnt", 32'(sample_cnt), 32'd0);
    cur.delete();
    exp_q.delete();
    model_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_s_ready", 32'(s_ready), 32'd1);
  endtask

  task automatic check_cnt(input string tag);
    check_eq(tag, 32'(sample_cnt), 32'(model_cnt % (1 << CNT_W)));
  endtask

  initial begin
    bit done;
    int t0;

    // Test 1: full sample, m_ready high
    do_reset();
    m_ready = 1'b1;
    send_beat(0, 0); send_beat(32, 0); send_beat(95, 0);
    send_beat(96, 0); send_beat(224, 0); send_beat(255, 1);
    check_eq("t1_m_valid", 32'(m_valid), 32'd1);
    check_eq("t1_feats", 32'(outs()), 32'({3'd0, 3'd1, 3'd2, 3'd3, 3'd7, 3'd7}));
    check_eq("t1_short", 32'(m_short), 32'd0);
    check_eq("t1_cnt0", 32'(sample_cnt), 32'd0);
    @(negedge clk);
    check_eq("t1_cnt1", 32'(sample_cnt), 32'd1);
    check_eq("t1_drained", 32'(m_valid), 32'd0);

    // Test 2: short sample
    send_beat(200, 0); send_beat(40, 0); send_beat(130, 1);
    check_eq("t2_feats", 32'(outs()), 32'({3'd6, 3'd1, 3'd4, 3'd0, 3'd0, 3'd0}));
    check_eq("t2_short", 32'(m_short), 32'd1);
    @(negedge clk);
    check_cnt("t2_cnt");

    // Test 3: backpressure into HOLD
    do_reset();
    m_ready = 1'b0;
    send_rand_sample(6, 1);
    send_rand_sample(6, 0);
    check_eq("t3_hold_s_ready", 32'(s_ready), 32'd0);
    check_eq("t3_hold_m_valid", 32'(m_valid), 32'd1);
    check_eq("t3_pending", 32'(exp_q.size()), 32'd2);
    repeat (3) @(negedge clk);
    check_eq("t3_stable", 32'({m_short, outs()}), 32'(exp_q[0]));
    check_eq("t3_still_blocked", 32'(s_ready), 32'd0);
    m_ready = 1'b1;
    @(negedge clk);
    check_eq("t3_cnt1", 32'(sample_cnt), 32'd1);
    check_eq("t3_second_valid", 32'(m_valid), 32'd1);
    check_eq("t3_refill_s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    check_eq("t3_cnt2", 32'(sample_cnt), 32'd2);
    check_eq("t3_empty", 32'(m_valid), 32'd0);

    // Test 4: continuous streaming, 60 beats
    do_reset();
    m_ready = 1'b1;
    track_ready = 1;
    ready_drops = 0;
    t0 = int'($time);
    for (int s = 0; s < 10; s++) send_rand_sample(6, 1);
    track_ready = 0;
    check_eq("t4_cycles", 32'((int'($time) - t0) / 10), 32'd60);
    check_eq("t4_ready_drops", 32'(ready_drops), 32'd0);
    @(negedge clk);
    check_cnt("t4_cnt");

    // Test 5: reset in the middle of a sample with a sample waiting at the output
    m_ready = 1'b0;
    send_rand_sample(6, 1);
    send_rand_sample(4, 0);
    check_eq("t5_pre_valid", 32'(m_valid), 32'd1);
    do_reset();
    m_ready = 1'b1;
    send_beat(10, 0); send_beat(70, 0); send_beat(100, 0);
    send_beat(170, 0); send_beat(193, 0); send_beat(250, 1);
    check_eq("t5_fresh", 32'(outs()), 32'({3'd0, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7}));
    @(negedge clk);
    check_cnt("t5_cnt");

    // Test 6: counter wrap at CNT_W=4
    do_reset();
    m_ready = 1'b1;
    for (int s = 0; s < 17; s++) send_rand_sample(6, ($urandom_range(0, 1) == 1));
    repeat (2) @(negedge clk);
    check_eq("t6_wrap", 32'(sample_cnt), 32'd1);
    check_cnt("t6_cnt");

    // Test 7: random lengths, gaps and consumer stalls
    do_reset();
    done = 0;
    fork
      begin
        for (int s = 0; s < 40; s++) begin
          int len;
          len = int'($urandom_range(1, 6));
          for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_beat(int'($urandom_range(0, 255)), (i == len - 1) && (len < 6 || $urandom_range(0, 1) == 1));
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          m_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("t7_drained", 32'(exp_q.size()), 32'd0);
    check_cnt("t7_cnt");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
